// File: rtl/st7735_spi_sink_pkg.sv
// st7735_spi_sink_pkg
//  Shared definitions for the ST7735 SPI sink: command opcodes, command FSM
//  state encoding and the default panel geometry.
package st7735_spi_sink_pkg;

  localparam int DEFAULT_COLS = 160;
  localparam int DEFAULT_ROWS = 128;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PARAM,
    ST_PIX_HI,
    ST_PIX_LO
  } fsm_state_t;

  // Last valid address of an axis of n pixels, as an 8-bit window bound.
  function automatic logic [7:0] last_index(input int n);
    return 8'(n - 1);
  endfunction

endpackage

// File: rtl/st7735_spi_sink_if.sv
// st7735_spi_sink_if
//  The 4-wire ST7735 link as seen at the panel.
//  sclk : SPI clock, idle high, data sampled on the rising edge
//  mosi : serial data, MSB first
//  dc   : 0 = command byte, 1 = data/parameter byte
//  cs   : active-low chip select
//  master drives the link (host / testbench), slave receives it (the sink).
interface st7735_spi_sink_if;
  logic sclk;
  logic mosi;
  logic dc;
  logic cs;

  modport master (output sclk, output mosi, output dc, output cs);
  modport slave  (input  sclk, input  mosi, input  dc, input  cs);
endinterface

// File: rtl/st7735_spi_sink_spi_byte_rx.sv
// spi_byte_rx
//  Oversampling SPI byte receiver. Synchronises SCLK/MOSI/DC/CS into clk,
//  detects SCLK rising edges and assembles MSB-first bytes.
//  Ports:
//   clk, reset   system clock, async active-high reset
//   sclk/mosi/dc/cs  raw SPI inputs
//   byte_valid   one-clk strobe, rx_byte/byte_dc valid
//   rx_byte      received byte
//   byte_dc      DC level sampled with the 8th bit
//   framing_err  one-clk strobe when CS rises with 1..7 bits shifted
//  SYNC_STAGES must be at least 2.
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       dc,
  input  logic       cs,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       byte_dc,
  output logic       framing_err
);

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, dc_sync, cs_sync;
  logic       sclk_prev;
  logic [6:0] shift_reg;
  logic [2:0] bit_cnt;
  logic       sclk_s, mosi_s, dc_s, cs_s, sclk_rise;

  // SCLK and CS come out of reset at their idle (high) level so that the
  // first clocks after reset do not look like an edge or a selected link.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '1;
      mosi_sync <= '0;
      dc_sync   <= '0;
      cs_sync   <= '1;
      sclk_prev <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], dc};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_prev <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign dc_s      = dc_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;

  // A deselected link has priority over a simultaneous SCLK edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      byte_valid  <= 1'b0;
      rx_byte     <= '0;
      byte_dc     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
      if (cs_s) begin
        framing_err <= (bit_cnt != 3'd0);
        bit_cnt     <= '0;
      end else if (sclk_rise) begin
        if (bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          rx_byte    <= {shift_reg, mosi_s};
          byte_dc    <= dc_s;
          bit_cnt    <= '0;
        end else begin
          shift_reg <= {shift_reg[5:0], mosi_s};
          bit_cnt   <= bit_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/st7735_spi_sink.sv
// st7735_spi_sink
//  Display-side responder for the ST7735 SPI link. Decodes the command
//  subset (SWRESET, SLPOUT, DISPOFF, DISPON, CASET, RASET, RAMWR) and turns
//  RAMWR data into addressed RGB565 framebuffer writes.
//  Ports:
//   clk, reset   system clock (>= 4x SCLK), async active-high reset
//   spi          SPI link, slave modport
//   pix_valid    one-clk strobe, pix_x/pix_y/pix_data valid
//   pix_x/pix_y  column/row of the written pixel
//   pix_data     RGB565 pixel, first byte received in [15:8]
//   cmd_valid    one-clk strobe per command byte, cmd_byte = opcode
//   sleep_out    set by SLPOUT, cleared by SWRESET
//   display_on   set by DISPON, cleared by DISPOFF/SWRESET
//   frame_done   one-clk strobe when the write pointer wraps past (xe,ye)
//   framing_err  one-clk strobe when CS rises mid-byte
module st7735_spi_sink
  import st7735_spi_sink_pkg::*;
#(
  parameter int COLS        = DEFAULT_COLS,
  parameter int ROWS        = DEFAULT_ROWS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  st7735_spi_sink_if.slave        spi,
  output logic                    pix_valid,
  output logic [7:0]              pix_x,
  output logic [7:0]              pix_y,
  output logic [15:0]             pix_data,
  output logic                    cmd_valid,
  output logic [7:0]              cmd_byte,
  output logic                    sleep_out,
  output logic                    display_on,
  output logic                    frame_done,
  output logic                    framing_err
);

  localparam logic [8:0] COLS_W = 9'(COLS);
  localparam logic [8:0] ROWS_W = 9'(ROWS);
  localparam logic [7:0] XE_DEF = last_index(COLS);
  localparam logic [7:0] YE_DEF = last_index(ROWS);

  logic       byte_valid, byte_dc;
  logic [7:0] rx_byte;

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk         (clk),
    .reset       (reset),
    .sclk        (spi.sclk),
    .mosi        (spi.mosi),
    .dc          (spi.dc),
    .cs          (spi.cs),
    .byte_valid  (byte_valid),
    .rx_byte     (rx_byte),
    .byte_dc     (byte_dc),
    .framing_err (framing_err)
  );

  fsm_state_t state, state_next;
  logic [7:0] xs, xe, ys, ye, x, y;
  logic [7:0] s_lo, hi_byte;
  logic [1:0] param_idx;
  logic       param_row;
  logic       is_cmd, is_data, in_range, pix_fire, frame_fire, param_commit;

  assign is_cmd   = byte_valid & ~byte_dc;
  assign is_data  = byte_valid & byte_dc;
  assign in_range = ({1'b0, x} < COLS_W) && ({1'b0, y} < ROWS_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // A command byte always overrides whatever the FSM was collecting.
  always_comb begin
    state_next   = state;
    pix_fire     = 1'b0;
    frame_fire   = 1'b0;
    param_commit = 1'b0;
    if (is_cmd) begin
      case (rx_byte)
        CMD_CASET, CMD_RASET: state_next = ST_PARAM;
        CMD_RAMWR:            state_next = ST_PIX_HI;
        default:              state_next = ST_IDLE;
      endcase
    end else if (is_data) begin
      case (state)
        ST_PARAM: begin
          if (param_idx == 2'd3) begin
            state_next   = ST_IDLE;
            param_commit = (s_lo <= rx_byte);
          end
        end
        ST_PIX_HI: state_next = ST_PIX_LO;
        ST_PIX_LO: begin
          state_next = ST_PIX_HI;
          pix_fire   = in_range;
          frame_fire = (x == xe) && (y == ye);
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Window, pointer and status registers. The pointer advances even for
  // off-panel pixels so the stream stays aligned with the host's view.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xs         <= '0;
      xe         <= XE_DEF;
      ys         <= '0;
      ye         <= YE_DEF;
      x          <= '0;
      y          <= '0;
      s_lo       <= '0;
      hi_byte    <= '0;
      param_idx  <= '0;
      param_row  <= 1'b0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_data   <= '0;
      cmd_valid  <= 1'b0;
      cmd_byte   <= '0;
      sleep_out  <= 1'b0;
      display_on <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      cmd_valid  <= 1'b0;
      pix_valid  <= pix_fire;
      frame_done <= frame_fire;
      if (is_cmd) begin
        cmd_valid <= 1'b1;
        cmd_byte  <= rx_byte;
        case (rx_byte)
          CMD_SWRESET: begin
            xs         <= '0;
            xe         <= XE_DEF;
            ys         <= '0;
            ye         <= YE_DEF;
            sleep_out  <= 1'b0;
            display_on <= 1'b0;
          end
          CMD_SLPOUT:  sleep_out  <= 1'b1;
          CMD_DISPON:  display_on <= 1'b1;
          CMD_DISPOFF: display_on <= 1'b0;
          CMD_CASET: begin
            param_idx <= '0;
            param_row <= 1'b0;
          end
          CMD_RASET: begin
            param_idx <= '0;
            param_row <= 1'b1;
          end
          CMD_RAMWR: begin
            x <= xs;
            y <= ys;
          end
          default: ;
        endcase
      end else if (is_data) begin
        case (state)
          ST_PARAM: begin
            param_idx <= param_idx + 2'd1;
            if (param_idx == 2'd1) s_lo <= rx_byte;
            if (param_commit) begin
              if (param_row) begin
                ys <= s_lo;
                ye <= rx_byte;
              end else begin
                xs <= s_lo;
                xe <= rx_byte;
              end
            end
          end
          ST_PIX_HI: hi_byte <= rx_byte;
          ST_PIX_LO: begin
            pix_x    <= x;
            pix_y    <= y;
            pix_data <= {hi_byte, rx_byte};
            if (x == xe) begin
              x <= xs;
              if (y == ye) y <= ys;
              else         y <= y + 8'd1;
            end else begin
              x <= x + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
